mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - Load/store unit between the pipeline MEM stage and main memory (mem_main).
// - Takes one load/store request at a time over a valid/ready handshake and drives
//   mem_main's write_en/address/write_data.
// - Returns load data, zero- or sign-extended, as a registered response.
// - Implements byte stores as read-modify-write, because mem_main always writes
//   16 bits: {mem[a+1], mem[a]}, little-endian, byte-addressed.
// PARAMETERS
// - AW  16  address width; must equal the mem_main address width.
// - DW  16  data width; must be 16; the byte lane is DW[7:0].
// PORTS
// - clk             in   1   clock, rising edge
// - rst             in   1   reset, asynchronous, active-high
// - halt_sys        in   1   system halt; freezes all state, suppresses writes
// - req_valid       in   1   request present
// - req_ready       out  1   request accepted when req_valid & req_ready
// - req_we          in   1   1 = store, 0 = load
// - req_byte        in   1   1 = byte access, 0 = word access
// - req_sext        in   1   byte load only: 1 = sign-extend, 0 = zero-extend
// - req_addr        in   AW  byte address
// - req_wdata       in   DW  store data; byte store uses [7:0]
// - rsp_valid       out  1   load data valid, one-cycle pulse
// - rsp_rdata       out  DW  load data
// - stall           out  1   to pipeline: (state != IDLE) | halt_sys
// - mem_write_en    out  1   to mem_main.write_en
// - mem_address     out  AW  to mem_main.address; always the registered addr_q
// - mem_write_data  out  DW  to mem_main.write_data
// - mem_data_out    in   DW  from mem_main.data_out (combinational read)
// - misalign_fault  out  1   only present when ALIGN_CHECK_EN is defined
// BEHAVIOUR
// - Reset (async): state = IDLE; addr_q, wdata_q, old_q, rsp_rdata = 0;
//   rsp_valid = 0; mem_write_en = 0; mem_address = 0; misalign_fault = 0.
// - FSM has three states: IDLE, ACCESS, MERGE.
// - IDLE:
//   - req_ready = !halt_sys.
//   - On accept, register addr, wdata, we, byte, sext; go to ACCESS.
// - ACCESS (mem_address = addr_q):
//   - Word store: mem_write_en = 1, mem_write_data = wdata_q; go to IDLE.
//   - Load: rsp_rdata <= word; or for a byte load, {8{sext & d[7]}, d[7:0]}.
//     rsp_valid <= 1; go to IDLE.
//   - Byte store: old_q <= mem_data_out; no write this cycle; go to MERGE.
// - MERGE: mem_write_en = 1, mem_write_data = {old_q[15:8], wdata_q[7:0]}; go to IDLE.
// - Latency (accept at edge T):
//   - Load: rsp_valid high in cycle T+2.
//   - Word store: commits at edge T+2.
//   - Byte store: commits at edge T+3.
//   - req_ready is low in ACCESS and MERGE, so there is no back-to-back acceptance.
// - rsp_valid is a one-cycle pulse. rsp_rdata holds its value until the next load.
// - halt_sys = 1 in any state:
//   - FSM, registers and rsp_valid hold.
//   - mem_write_en is forced 0, req_ready is 0, stall is 1.
//   - Operation resumes unchanged on the cycle halt_sys drops.
// - Address wrap: no arithmetic is done here; addr_q is passed through unmodified,
//   so a word at 0xFFFF pairs bytes 0xFFFF and 0x0000 inside mem_main.
// - Reset mid-operation: the pending store is abandoned with no partial write,
//   and a pending load produces no response.
// - Only the MERGE state writes the byte pair. The write is registered-address
//   stable, so no write glitches during ACCESS.
// CONFIGURATION
// - Macro ALIGN_CHECK_EN.
// - Defined:
//   - A word access with addr[0] = 1 is accepted, but in ACCESS it sets
//     misalign_fault = 1 for one cycle.
//   - The store is suppressed (mem_write_en stays 0).
//   - A load returns rsp_valid = 1 with rsp_rdata = 0x0000.
//   - Byte accesses never fault.
// - Undefined: the port is absent, and odd word accesses are performed as-is.
// TESTING
// - Word store 0xBEEF @0x0010, then word load @0x0010 -> write_en high for 1 cycle,
//   rsp_rdata = 0xBEEF, rsp_valid at accept + 2.
// - Mem @0x0020 = 0x1234; byte store 0xAB @0x0020 -> two-cycle RMW; word load
//   returns 0x12AB; stall high for 2 cycles.
// - Mem @0x0030 = 0x0085; byte load with sext = 1 -> 0xFF85; with sext = 0 -> 0x0085.
// - halt_sys asserted in MERGE for 3 cycles -> no write while halted; write
//   occurs the cycle after release; final data is correct.
// - rst pulsed in ACCESS of a word store 0x5555 @0x0040 -> no write, state IDLE,
//   all outputs 0.
// - ALIGN_CHECK_EN defined: word store @0x0041 -> misalign_fault pulse and memory
//   unchanged; load @0x0041 -> rsp 0x0000.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store unit between the MEM stage and mem_main; byte stores are done as read-modify-write.
// Optional macro ALIGN_CHECK_EN adds misalign_fault and suppresses odd-address word accesses.
module mem_access_ctrl #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          halt_sys,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic          req_byte,
   input  logic          req_sext,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          stall,
   output logic          mem_write_en,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_write_data,
   input  logic [DW-1:0] mem_data_out
`ifdef ALIGN_CHECK_EN
   ,
   output logic          misalign_fault
`endif
);

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-9:0] old_hi_q;
   logic [DW-1:0] wr_data_q;
   logic          we_q;
   logic          byte_q;
   logic          sext_q;
   logic          wr_q;
   logic          odd_word;

`ifdef ALIGN_CHECK_EN
   assign odd_word = !byte_q && addr_q[0];
`else
   assign odd_word = 1'b0;
`endif

   assign req_ready      = (state == IDLE) && !halt_sys;
   assign stall          = (state != IDLE) || halt_sys;
   assign mem_address    = addr_q;
   assign mem_write_data = wr_data_q;
   // The write strobe is registered so it holds through a halt; halt only masks it.
   assign mem_write_en   = wr_q && !halt_sys;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         old_hi_q  <= '0;
         wr_data_q <= '0;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         sext_q    <= 1'b0;
         wr_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef ALIGN_CHECK_EN
         misalign_fault <= 1'b0;
`endif
      end else if (!halt_sys) begin
         wr_q      <= 1'b0;
         rsp_valid <= 1'b0;
`ifdef ALIGN_CHECK_EN
         misalign_fault <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  we_q    <= req_we;
                  byte_q  <= req_byte;
                  sext_q  <= req_sext;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               state <= IDLE;
               if (odd_word) begin
`ifdef ALIGN_CHECK_EN
                  misalign_fault <= 1'b1;
`endif
                  if (!we_q) begin
                     rsp_rdata <= '0;
                     rsp_valid <= 1'b1;
                  end
               end else if (!we_q) begin
                  rsp_rdata <= byte_q ? {{(DW-8){sext_q & mem_data_out[7]}}, mem_data_out[7:0]}
                                      : mem_data_out;
                  rsp_valid <= 1'b1;
               end else if (byte_q) begin
                  old_hi_q <= mem_data_out[DW-1:8];
                  state    <= MERGE;
               end else begin
                  wr_q      <= 1'b1;
                  wr_data_q <= wdata_q;
               end
            end
            MERGE: begin
               wr_q      <= 1'b1;
               wr_data_q <= {old_hi_q, wdata_q[7:0]};
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural byte-addressed mem_main model.
// Build with ALIGN_CHECK_EN defined to exercise the misalignment checks.
module tb_mem_access_ctrl;
   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          halt_sys = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic          req_byte = 1'b0;
   logic          req_sext = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready, rsp_valid, stall, mem_write_en;
   logic [DW-1:0] rsp_rdata, mem_write_data, mem_data_out;
   logic [AW-1:0] mem_address, addr_p1;
`ifdef ALIGN_CHECK_EN
   logic          misalign_fault;
`endif

   logic [7:0]  mem [0:65535];
   logic        pre_en = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [15:0] pre_data = '0;

   int unsigned cyc = 0, wr_cnt = 0, stall_cnt = 0, fault_cnt = 0, rsp_cnt = 0;
   int unsigned last_wr_cyc = 0, issue_cyc = 0, n_checks = 0, n_errors = 0;

   typedef struct {
      logic [15:0] data;
      int unsigned cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_access_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .halt_sys(halt_sys),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .stall(stall), .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_data_out(mem_data_out)
`ifdef ALIGN_CHECK_EN
      , .misalign_fault(misalign_fault)
`endif
   );

   assign addr_p1      = mem_address + 16'd1;
   assign mem_data_out = {mem[addr_p1], mem[mem_address]};

   always @(posedge clk) begin
      logic [15:0] pa1;
      pa1 = pre_addr + 16'd1;
      cyc <= cyc + 1;
      if (pre_en) begin
         mem[pre_addr] <= pre_data[7:0];
         mem[pa1]      <= pre_data[15:8];
      end else if (mem_write_en) begin
         mem[mem_address] <= mem_write_data[7:0];
         mem[addr_p1]     <= mem_write_data[15:8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rd16(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   always @(negedge clk) begin
      if (mem_write_en) begin
         wr_cnt++;
         last_wr_cyc = cyc;
      end
      if (stall) stall_cnt++;
`ifdef ALIGN_CHECK_EN
      if (misalign_fault) fault_cnt++;
`endif
      if (rsp_valid) begin
         rsp_cnt++;
         if (sb.size() == 0) check("unexpected_rsp", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_data", rsp_rdata, e.data);
            check("rsp_latency", cyc, e.cyc);
         end
      end
   end

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic issue(input logic we, input logic bt, input logic sx,
                        input logic [15:0] a, input logic [15:0] wd, input logic [15:0] exp);
      int unsigned n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_ready", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_byte = bt; req_sext = sx;
      req_addr = a; req_wdata = wd;
      issue_cyc = cyc;
      if (!we) sb.push_back('{exp, cyc + 2});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((stall || mem_write_en || sb.size() != 0) && n < 100);
      if (n >= 100) check("idle_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, req_ready, 1);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_we"}, mem_write_en, 0);
      check({tag, "_addr"}, mem_address, 0);
      check({tag, "_wdata"}, mem_write_data, 0);
      check({tag, "_rvalid"}, rsp_valid, 0);
      check({tag, "_rdata"}, rsp_rdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w0, r0, f0;
      #1;
      check_reset_outputs("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Word store then word load
      w0 = wr_cnt; stall_cnt = 0;
      issue(1, 0, 0, 16'h0010, 16'hBEEF, 16'h0);
      wait_idle();
      check("ws_mem", rd16(16'h0010), 16'hBEEF);
      check("ws_wr_cnt", wr_cnt - w0, 1);
      check("ws_commit", last_wr_cyc - issue_cyc, 2);
      check("ws_stall", stall_cnt, 1);
      issue(0, 0, 0, 16'h0010, 16'h0, 16'hBEEF);
      wait_idle();

      // Byte store read-modify-write
      preload(16'h0020, 16'h1234);
      w0 = wr_cnt; stall_cnt = 0;
      issue(1, 1, 0, 16'h0020, 16'h77AB, 16'h0);
      wait_idle();
      check("bs_mem", rd16(16'h0020), 16'h12AB);
      check("bs_wr_cnt", wr_cnt - w0, 1);
      check("bs_commit", last_wr_cyc - issue_cyc, 3);
      check("bs_stall", stall_cnt, 2);
      issue(0, 0, 0, 16'h0020, 16'h0, 16'h12AB);
      wait_idle();

      // Byte loads: sign/zero extension and odd-address lane
      preload(16'h0030, 16'h0085);
      issue(0, 1, 1, 16'h0030, 16'h0, 16'hFF85);
      issue(0, 1, 0, 16'h0030, 16'h0, 16'h0085);
      preload(16'h0032, 16'h9C00);
      issue(0, 1, 1, 16'h0033, 16'h0, 16'hFF9C);
      issue(0, 1, 1, 16'h0032, 16'h0, 16'h0000);
      wait_idle();

      // Address wrap at 0xFFFF
      preload(16'hFFFF, 16'h1234);
`ifdef ALIGN_CHECK_EN
      issue(0, 0, 0, 16'hFFFF, 16'h0, 16'h0000);
`else
      issue(0, 0, 0, 16'hFFFF, 16'h0, 16'h1234);
`endif
      wait_idle();

      // Halt held for three cycles while in MERGE
      preload(16'h0050, 16'h5678);
      w0 = wr_cnt;
      issue(1, 1, 0, 16'h0050, 16'h009A, 16'h0);
      @(negedge clk);
      halt_sys = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("halt_we", mem_write_en, 0);
         check("halt_stall", stall, 1);
         check("halt_ready", req_ready, 0);
      end
      check("halt_mem", rd16(16'h0050), 16'h5678);
      halt_sys = 1'b0;
      @(negedge clk);
      check("release_we", mem_write_en, 1);
      wait_idle();
      check("halt_final", rd16(16'h0050), 16'h569A);
      check("halt_wr_cnt", wr_cnt - w0, 1);

      // Reset during ACCESS of a word store
      preload(16'h0040, 16'hA1A1);
      w0 = wr_cnt;
      issue(1, 0, 0, 16'h0040, 16'h5555, 16'h0);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_ws");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ws_mem", rd16(16'h0040), 16'hA1A1);
      check("rst_ws_wr_cnt", wr_cnt - w0, 0);

      // Reset during ACCESS of a load: no response may follow
      r0 = rsp_cnt;
      issue(0, 0, 0, 16'h0010, 16'h0, 16'hBEEF);
      rst = 1'b1;
      #1;
      sb.delete();
      check("rst_ld_stall", stall, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_ld_rsp", rsp_cnt - r0, 0);
      issue(0, 0, 0, 16'h0020, 16'h0, 16'h12AB);
      wait_idle();

`ifdef ALIGN_CHECK_EN
      // Odd word accesses fault; byte accesses never do
      preload(16'h0041, 16'h7788);
      w0 = wr_cnt; f0 = fault_cnt;
      issue(1, 0, 0, 16'h0041, 16'h5555, 16'h0);
      wait_idle();
      check("mis_st_fault", fault_cnt - f0, 1);
      check("mis_st_wr_cnt", wr_cnt - w0, 0);
      check("mis_st_mem", rd16(16'h0041), 16'h7788);
      f0 = fault_cnt;
      issue(0, 0, 0, 16'h0041, 16'h0, 16'h0000);
      wait_idle();
      check("mis_ld_fault", fault_cnt - f0, 1);
      f0 = fault_cnt;
      issue(0, 1, 0, 16'h0041, 16'h0, 16'h0088);
      wait_idle();
      check("byte_no_fault", fault_cnt - f0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
